// File: rtl/lsu_pkg.sv
// Shared definitions for the pipelined load/store unit: op encodings, the
// pending-entry record, and the lane/byte-enable/extension helpers.
package lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] off;
    logic [4:0] rd;
  } pend_t;

  // size: funct3[1:0] (0 byte, 1 half, else word)
  function automatic logic [3:0] be_gen(input logic is_store, input logic [1:0] size,
                                        input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (is_store) begin
      case (size)
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] wdata_align(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{wdata[7:0]}};
      2'b01:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    logic [31:0]        r;
    b  = rdata[{off, 3'b000} +: 8];
    h  = off[1] ? rdata[31:16] : rdata[15:0];
    sx = 32'sd0;
    r  = rdata;
    case (f3[1:0])
      2'b00: begin
        sx = b;
        r  = f3[2] ? {24'h0, b} : sx;
      end
      2'b01: begin
        sx = h;
        r  = f3[2] ? {16'h0, h} : sx;
      end
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_pipelined_if.sv
// OBI-style data port between the LSU (master) and memory (slave).
interface lsu_pipelined_if;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_rvalid_i;
  logic        data_gnt_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_rdata_i, data_rvalid_i, data_gnt_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_rdata_i, data_rvalid_i, data_gnt_i
  );
endinterface

// File: rtl/lsu_pending_fifo.sv
// In-order tracker of granted transactions awaiting rvalid; push and pop may
// happen in the same cycle.
module lsu_pending_fifo
  import lsu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  pend_t            wdata_i,
  output pend_t            rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  pend_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lsu_pipelined.sv
// Pipelined load/store unit: issues EXEC ops onto an OBI data port, tracks them
// in order, and returns tagged, extended responses. Option: LSU_MISALIGN_TRAP_EN.
module lsu_pipelined
  import lsu_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] PERIPH_MIN      = 32'h0000_0600,
  parameter logic [31:0] PERIPH_MAX      = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  input  logic [31:0] memory_offset_i,
  input  logic        stop_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_is_store_o,
  output logic        idle_o,
  output logic        in_range_peripheral_o,
  output logic        protocol_err_o,
  output logic        misalign_o,
  lsu_pipelined_if.master bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  pend_t            head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             can_issue, trap, issue, push, pop;
  logic             is_store;
  logic [31:0]      resp_rdata_d;

  logic             resp_valid_q, resp_is_store_q, prot_err_q;
  logic [31:0]      resp_rdata_q;
  logic [4:0]       resp_rd_q;

  assign is_store  = req_op_i[3];
  assign can_issue = req_valid_i & ~fifo_full & ~stop_i;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap       = can_issue & misaligned(req_op_i[1:0], req_addr_i[1:0]);
  assign misalign_o = misalign_q;

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= trap;
  end
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // A trapped op is consumed without touching the bus.
  assign issue       = can_issue & ~trap;
  assign push        = issue & bus.data_gnt_i;
  assign req_ready_o = push | trap;
  assign pop         = bus.data_rvalid_i & ~fifo_empty;

  assign bus.data_req_o   = issue;
  assign bus.data_addr_o  = issue ? (req_addr_i - memory_offset_i) : '0;
  assign bus.data_we_o    = issue & is_store;
  assign bus.data_be_o    = issue ? be_gen(is_store, req_op_i[1:0], req_addr_i[1:0]) : '0;
  assign bus.data_wdata_o = (issue && is_store) ? wdata_align(req_op_i[1:0], req_wdata_i) : '0;

  lsu_pending_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ('{op: req_op_i, off: req_addr_i[1:0], rd: req_rd_i}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign resp_rdata_d = head.op[3] ? 32'h0 : load_ext(head.op[2:0], head.off, bus.data_rdata_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_rd_q       <= '0;
      resp_is_store_q <= 1'b0;
      prot_err_q      <= 1'b0;
    end else begin
      resp_valid_q <= pop;
      prot_err_q   <= prot_err_q | (bus.data_rvalid_i & fifo_empty);
      if (pop) begin
        resp_rdata_q    <= resp_rdata_d;
        resp_rd_q       <= head.rd;
        resp_is_store_q <= head.op[3];
      end else if (trap) begin
        resp_rd_q <= req_rd_i;
      end
    end
  end

  assign resp_valid_o          = resp_valid_q;
  assign resp_rdata_o          = resp_rdata_q;
  assign resp_rd_o             = resp_rd_q;
  assign resp_is_store_o       = resp_is_store_q;
  assign protocol_err_o        = prot_err_q;
  assign idle_o                = (fifo_count == '0) & ~issue;
  assign in_range_peripheral_o = (req_addr_i >= PERIPH_MIN) && (req_addr_i < PERIPH_MAX);

endmodule

// File: tb/tb_lsu_pipelined.sv
// Scoreboard bench for lsu_pipelined: a memory responder with programmable
// rvalid latency, plus a monitor that checks responses in order.
module tb_lsu_pipelined;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i, req_ready_o, stop_i;
  logic [3:0]  req_op_i;
  logic [31:0] req_addr_i, req_wdata_i, memory_offset_i;
  logic [4:0]  req_rd_i;
  logic        resp_valid_o, resp_is_store_o, idle_o, in_range_peripheral_o;
  logic        protocol_err_o, misalign_o;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_o;

  lsu_pipelined_if bus ();

  lsu_pipelined #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .memory_offset_i(memory_offset_i), .stop_i(stop_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_rd_o(resp_rd_o),
    .resp_is_store_o(resp_is_store_o), .idle_o(idle_o),
    .in_range_peripheral_o(in_range_peripheral_o), .protocol_err_o(protocol_err_o),
    .misalign_o(misalign_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0, cyc = 0, lat = 1;
  logic stray = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [4:0] rd; logic [31:0] rdata; logic st; } resp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } busx_t;
  typedef struct { int due; logic [31:0] d; } infl_t;
  resp_t       sbq[$];
  busx_t       bxq[$];
  infl_t       infl[$];
  logic [31:0] rq[$];
  int          rvq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory side: returns rvalid 'lat' cycles after each grant, in order.
  initial begin
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (infl.size() > 0 && infl[0].due <= cyc) begin
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = infl[0].d;
        void'(infl.pop_front());
        rvq.push_back(cyc);
      end else begin
        bus.data_rvalid_i = stray;
        bus.data_rdata_i  = stray ? 32'hBAD0_BAD0 : '0;
      end
      if (bus.data_req_o && bus.data_gnt_i) begin
        if (bxq.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL bus_unexpected: got addr %h expected no request", bus.data_addr_o);
        end else begin
          busx_t e;
          e = bxq.pop_front();
          chk("bus_addr", bus.data_addr_o, e.addr);
          chk("bus_we", 32'(bus.data_we_o), 32'(e.we));
          chk("bus_be", 32'(bus.data_be_o), 32'(e.be));
          chk("bus_wdata", bus.data_wdata_o, e.wdata);
        end
        infl.push_back('{cyc + lat, (rq.size() > 0) ? rq.pop_front() : 32'h0});
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid_o) begin
        if (sbq.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL resp_unexpected: got rd %0d expected no response", resp_rd_o);
        end else begin
          resp_t e;
          e = sbq.pop_front();
          chk("resp_rd", 32'(resp_rd_o), 32'(e.rd));
          chk("resp_rdata", resp_rdata_o, e.rdata);
          chk("resp_is_store", 32'(resp_is_store_o), 32'(e.st));
          if (rvq.size() > 0) chk("resp_latency", 32'(cyc), 32'(rvq.pop_front() + 1));
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] mrd, input logic [31:0] xrd,
                       input logic [3:0] xbe, input logic [31:0] xwd, output int gcyc);
    sbq.push_back('{rd, xrd, op[3]});
    bxq.push_back('{addr - memory_offset_i, op[3], xbe, xwd});
    rq.push_back(mrd);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
    gcyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) begin gcyc = cyc; break; end
    end
    if (gcyc < 0) begin
      ncmp++; nfail++;
      $display("FAIL issue_timeout: got no req_ready_o expected ready for rd %0d", rd);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && infl.size() == 0 && idle_o) begin done = 1; break; end
    end
    if (!done) begin
      ncmp++; nfail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  int g, g1, g2, g3, gp;
  logic [31:0] v;

  initial begin
    reset = 1'b1; req_valid_i = 0; req_op_i = 0; req_addr_i = 0; req_wdata_i = 0;
    req_rd_i = 0; memory_offset_i = 0; stop_i = 0; bus.data_gnt_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'h0);
    chk("rst_resp_rdata", resp_rdata_o, 32'h0);
    chk("rst_prot_err", 32'(protocol_err_o), 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'h0);
    chk("rst_idle", 32'(idle_o), 32'h1);
    chk("rst_data_req", 32'(bus.data_req_o), 32'h0);

    // Peripheral window edges
    req_addr_i = 32'h5FF; #1 chk("periph_5ff", 32'(in_range_peripheral_o), 32'h0);
    req_addr_i = 32'h600; #1 chk("periph_600", 32'(in_range_peripheral_o), 32'h1);
    req_addr_i = 32'h7FF; #1 chk("periph_7ff", 32'(in_range_peripheral_o), 32'h1);
    req_addr_i = 32'h800; #1 chk("periph_800", 32'(in_range_peripheral_o), 32'h0);
    @(posedge clk); #1;

    // Stores and lane extraction
    issue(OP_SW,  32'h1000, 32'hDEADBEEF, 5'd1, 32'hFFFFFFFF, 32'h0, 4'b1111, 32'hDEADBEEF, g);
    issue(OP_LB,  32'h1003, 32'h0, 5'd2, 32'h80FFFF7F, 32'hFFFFFF80, 4'b1111, 32'h0, g);
    issue(OP_LBU, 32'h1003, 32'h0, 5'd3, 32'h80FFFF7F, 32'h00000080, 4'b1111, 32'h0, g);
    issue(OP_LH,  32'h1002, 32'h0, 5'd4, 32'h80FFFF7F, 32'hFFFF80FF, 4'b1111, 32'h0, g);
    issue(OP_LHU, 32'h1002, 32'h0, 5'd5, 32'h80FFFF7F, 32'h000080FF, 4'b1111, 32'h0, g);
    issue(OP_LB,  32'h1000, 32'h0, 5'd6, 32'h80FFFF7F, 32'h0000007F, 4'b1111, 32'h0, g);
    issue(OP_SB,  32'h1001, 32'h000000A5, 5'd7, 32'h1, 32'h0, 4'b0010, 32'hA5A5A5A5, g);
    issue(OP_SH,  32'h1002, 32'h00001234, 5'd8, 32'h1, 32'h0, 4'b1100, 32'h12341234, g);
    memory_offset_i = 32'h100;
    issue(OP_LW,  32'h1104, 32'h0, 5'd9, 32'h12345678, 32'h12345678, 4'b1111, 32'h0, g);
    memory_offset_i = 32'h0;
    drain();

    // stop_i while waiting for grant withdraws the request
    bus.data_gnt_i = 1'b0;
    req_valid_i = 1'b1; req_op_i = OP_LW; req_addr_i = 32'h2000; req_rd_i = 5'd30;
    @(negedge clk);
    chk("nogrant_req", 32'(bus.data_req_o), 32'h1);
    chk("nogrant_ready", 32'(req_ready_o), 32'h0);
    stop_i = 1'b1; #1;
    chk("stop_req", 32'(bus.data_req_o), 32'h0);
    @(posedge clk); #1;
    stop_i = 1'b0; req_valid_i = 1'b0; bus.data_gnt_i = 1'b1;

    // Outstanding limit with slow responses
    lat = 3;
    issue(OP_LW, 32'h3000, 32'h0, 5'd11, 32'h11111111, 32'h11111111, 4'b1111, 32'h0, g1);
    issue(OP_LW, 32'h3004, 32'h0, 5'd12, 32'h22222222, 32'h22222222, 4'b1111, 32'h0, g2);
    issue(OP_LB, 32'h3009, 32'h0, 5'd13, 32'h0000FE00, 32'hFFFFFFFE, 4'b1111, 32'h0, g3);
    chk("outst_second_gap", 32'(g2 - g1), 32'd1);
    chk("outst_third_gap", 32'(g3 - g1), 32'd4);
    drain();

    // Back-to-back with grant and rvalid coinciding
    lat = 1;
    gp = 0;
    for (int i = 0; i < 10; i++) begin
      v = 32'h01010101 * i;
      issue(OP_LW, 32'h4000 + 32'(4 * i), 32'h0, 5'(16 + i), v, v, 4'b1111, 32'h0, g);
      if (i > 0) chk("b2b_gap", 32'(g - gp), 32'd1);
      gp = g;
    end
    drain();
    chk("b2b_no_err", 32'(protocol_err_o), 32'h0);

    // Stray rvalid
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    @(negedge clk);
    chk("stray_err_set", 32'(protocol_err_o), 32'h1);
    repeat (3) @(negedge clk);
    chk("stray_err_sticky", 32'(protocol_err_o), 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("stray_err_cleared", 32'(protocol_err_o), 32'h0);
    chk("post_rst_idle", 32'(idle_o), 32'h1);
    @(posedge clk); #1;

`ifdef LSU_MISALIGN_TRAP_EN
    req_valid_i = 1'b1; req_op_i = OP_LW; req_addr_i = 32'h1002; req_rd_i = 5'd27;
    @(negedge clk);
    chk("trap_no_req", 32'(bus.data_req_o), 32'h0);
    chk("trap_ready", 32'(req_ready_o), 32'h1);
    @(posedge clk); #1 req_valid_i = 1'b0;
    @(negedge clk);
    chk("trap_pulse", 32'(misalign_o), 32'h1);
    chk("trap_rd", 32'(resp_rd_o), 32'd27);
    chk("trap_no_resp", 32'(resp_valid_o), 32'h0);
    @(negedge clk);
    chk("trap_pulse_end", 32'(misalign_o), 32'h0);
    @(posedge clk); #1;
`else
    issue(OP_LW, 32'h1002, 32'h0, 5'd27, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 32'h0, g);
    drain();
    chk("no_trap_misalign", 32'(misalign_o), 32'h0);
`endif
    drain();
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

endmodule
